// File: rtl/tmds_decoder.sv
// Single-channel DVI TMDS receive decoder: finds symbol alignment from control
// tokens in the deserialized stream, then decodes pixel data and control values.
module tmds_decoder #(
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOCK_TOKENS   = 8
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic [9:0] raw_in,
    output logic [7:0] d,
    output logic [1:0] c,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int WD_W  = $clog2(SEARCH_WINDOW);
    localparam int CNT_W = $clog2(LOCK_TOKENS + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(SEARCH_WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_TOKENS);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Returns {hit, control value} for the four TMDS control tokens.
    function automatic logic [2:0] tok_lookup(input logic [9:0] q);
        logic [2:0] r;
        case (q)
            10'h354: r = 3'b100;
            10'h0AB: r = 3'b101;
            10'h154: r = 3'b110;
            10'h2AB: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Undoes the optional inversion, then the XOR/XNOR transition chain.
    function automatic logic [7:0] tmds_data(input logic [9:0] q);
        logic [7:0] di;
        logic [7:0] r;
        di   = q[9] ? ~q[7:0] : q[7:0];
        r[0] = di[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = q[8] ? (di[i] ^ di[i-1]) : ~(di[i] ^ di[i-1]);
        end
        return r;
    endfunction

    logic [9:0]       prev_raw_q, prev_raw_d;
    logic [9:0]       aligned_q, aligned_d;
    logic [3:0]       offset_q, offset_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [1:0]       holdoff_q, holdoff_d;
    logic [7:0]       d_q, d_d;
    logic [1:0]       c_q, c_d;
    logic             de_q, de_d;
    logic             locked_q, locked_d;

    logic [19:0]      window_s;
    logic             tok_hit_s;
    logic [1:0]       tok_c_s;
    logic             tok_eff_s;
    logic             wd_exp_s;
    logic             slip_s;
    logic [CNT_W-1:0] tok_cnt_inc_s;

    // Word window extraction and token classification of the aligned word.
    always_comb begin
        prev_raw_d           = raw_in;
        window_s             = {raw_in, prev_raw_q};
        aligned_d            = 10'(window_s >> offset_q);
        {tok_hit_s, tok_c_s} = tok_lookup(aligned_q);
        // Right after a slip the aligned register still holds a word cut at the old offset.
        tok_eff_s            = tok_hit_s & (holdoff_q == 2'd0);
        wd_exp_s             = (wd_q == WD_MAX);
    end

    // Alignment FSM next state, slip, token counter and watchdog.
    always_comb begin
        state_d       = state_q;
        tok_cnt_d     = tok_cnt_q;
        slip_s        = 1'b0;
        tok_cnt_inc_s = tok_cnt_q + CNT_W'(1);
        case (state_q)
            ST_SEARCH: begin
                if (tok_eff_s) begin
                    state_d   = ST_VERIFY;
                    tok_cnt_d = CNT_W'(1);
                end else if (wd_exp_s) begin
                    slip_s = 1'b1;
                end else begin
                    slip_s = 1'b0;
                end
            end
            ST_VERIFY: begin
                if (tok_eff_s) begin
                    if (tok_cnt_inc_s >= CNT_LOCK) begin
                        state_d   = ST_LOCKED;
                        tok_cnt_d = CNT_LOCK;
                    end else begin
                        tok_cnt_d = tok_cnt_inc_s;
                    end
                end else begin
                    state_d   = ST_SEARCH;
                    tok_cnt_d = '0;
                    slip_s    = wd_exp_s;
                end
            end
            ST_LOCKED: begin
                if (!tok_eff_s && wd_exp_s) begin
                    state_d   = ST_SEARCH;
                    tok_cnt_d = '0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                tok_cnt_d = '0;
            end
        endcase

        if (slip_s) begin
            offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            holdoff_d = 2'd2;
        end else begin
            offset_d  = offset_q;
            holdoff_d = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;
        end

        if (tok_eff_s || slip_s || (state_d != state_q)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Output stage: control tokens and data symbols only pass while locked.
    always_comb begin
        d_d      = 8'd0;
        c_d      = 2'd0;
        de_d     = 1'b0;
        locked_d = (state_q == ST_LOCKED);
        if (state_q == ST_LOCKED) begin
            if (tok_hit_s) begin
                c_d = tok_c_s;
            end else begin
                de_d = 1'b1;
                d_d  = tmds_data(aligned_q);
                c_d  = c_q;
            end
        end else begin
            c_d = 2'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            prev_raw_q <= 10'd0;
            aligned_q  <= 10'd0;
            offset_q   <= 4'd0;
            state_q    <= ST_SEARCH;
            tok_cnt_q  <= '0;
            wd_q       <= '0;
            holdoff_q  <= 2'd0;
            d_q        <= 8'd0;
            c_q        <= 2'd0;
            de_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            prev_raw_q <= prev_raw_d;
            aligned_q  <= aligned_d;
            offset_q   <= offset_d;
            state_q    <= state_d;
            tok_cnt_q  <= tok_cnt_d;
            wd_q       <= wd_d;
            holdoff_q  <= holdoff_d;
            d_q        <= d_d;
            c_q        <= c_d;
            de_q       <= de_d;
            locked_q   <= locked_d;
        end
    end

    assign d      = d_q;
    assign c      = c_q;
    assign de     = de_q;
    assign locked = locked_q;
    assign offset = offset_q;

endmodule
